cdb_writeback_arbiter: RTL and testbench

//  Downstream of the functional-unit wrapper: collects completed results from N_FU producer

---
 rtl/cdb_writeback_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback_arbiter.sv
// Per-lane result FIFOs arbitrated round-robin onto CDB_PORTS broadcast ports.
// Define CDB_BYPASS_EN to let an empty lane's input go straight to the CDB.
module cdb_writeback_arbiter #(
    parameter int N_FU       = 4,
    parameter int CDB_PORTS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_DEPTH  = 8,
    parameter int PREG_COUNT = 64,
    localparam int RW = $clog2(ROB_DEPTH),
    localparam int PW = $clog2(PREG_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [N_FU-1:0]                 fu_valid,
    output logic [N_FU-1:0]                 fu_ready,
    input  logic [N_FU-1:0][RW-1:0]         fu_rob_id,
    input  logic [N_FU-1:0][PW-1:0]         fu_pd,
    input  logic [N_FU-1:0]                 fu_rd_we,
    input  logic [N_FU-1:0][31:0]           fu_value,
    output logic [CDB_PORTS-1:0]            cdb_valid,
    output logic [CDB_PORTS-1:0][RW-1:0]    cdb_rob_id,
    output logic [CDB_PORTS-1:0][PW-1:0]    cdb_pd,
    output logic [CDB_PORTS-1:0]            cdb_rd_we,
    output logic [CDB_PORTS-1:0][31:0]      cdb_value
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (N_FU > 1) ? $clog2(N_FU) : 1;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [PW-1:0] pd;
        logic          we;
        logic [31:0]   value;
    } ent_t;

    ent_t          mem    [N_FU][FIFO_DEPTH];
    logic [CW-1:0] cnt    [N_FU];
    logic [AW-1:0] hd     [N_FU];
    logic [AW-1:0] tl     [N_FU];
    logic [LW-1:0] rr;
    logic [LW-1:0] rr_nxt;

    ent_t          in_ent [N_FU];
    ent_t          hd_ent [N_FU];
    ent_t          pent   [CDB_PORTS];
    logic [LW-1:0] pl     [CDB_PORTS];
    logic [CDB_PORTS-1:0] pv;
    logic [N_FU-1:0] cand, grant, push, pop, byp;

    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            in_ent[i] = '{fu_rob_id[i], fu_pd[i], fu_rd_we[i], fu_value[i]};
            hd_ent[i] = mem[i][hd[i]];
            // Ready comes from the registered count only; held low in reset
            fu_ready[i] = rst && (cnt[i] != CW'(FIFO_DEPTH));
`ifdef CDB_BYPASS_EN
            cand[i] = (cnt[i] != '0) || (fu_valid[i] && fu_ready[i]);
`else
            cand[i] = (cnt[i] != '0);
`endif
        end
    end

    always_comb begin : arb
        logic [2*N_FU-1:0] dbl;
        logic [2*N_FU-1:0] dg;
        logic [N_FU-1:0]   rc;
        logic [N_FU-1:0]   grot;
        int                n;
        dbl    = {cand, cand} >> rr;
        rc     = dbl[N_FU-1:0];
        grot   = '0;
        pv     = '0;
        rr_nxt = rr;
        n      = 0;
        for (int p = 0; p < CDB_PORTS; p++) pl[p] = '0;
        // Scan in rotated order so bit k is lane (rr + k) mod N_FU
        for (int k = 0; k < N_FU; k++) begin
            if (rc[k] && n < CDB_PORTS) begin
                grot[k] = 1'b1;
                for (int p = 0; p < CDB_PORTS; p++) begin
                    if (p == n) begin
                        pv[p] = 1'b1;
                        pl[p] = LW'((int'(rr) + k) % N_FU);
                    end
                end
                rr_nxt = LW'((int'(rr) + k + 1) % N_FU);
                n++;
            end
        end
        dg    = {grot, grot} << rr;
        grant = dg[2*N_FU-1:N_FU];
    end

    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
`ifdef CDB_BYPASS_EN
            byp[i] = grant[i] && (cnt[i] == '0);
`else
            byp[i] = 1'b0;
`endif
            pop[i]  = grant[i] && (cnt[i] != '0);
            push[i] = fu_valid[i] && fu_ready[i] && !byp[i] && !flush;
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
            pent[p] = byp[pl[p]] ? in_ent[pl[p]] : hd_ent[pl[p]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (push[i]) mem[i][tl[i]] <= in_ent[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_FU; i++) begin
                cnt[i] <= '0;
                hd[i]  <= '0;
                tl[i]  <= '0;
            end
            rr         <= '0;
            cdb_valid  <= '0;
            cdb_rob_id <= '0;
            cdb_pd     <= '0;
            cdb_rd_we  <= '0;
            cdb_value  <= '0;
        end else if (flush) begin
            for (int i = 0; i < N_FU; i++) begin
                cnt[i] <= '0;
                hd[i]  <= '0;
                tl[i]  <= '0;
            end
            rr         <= '0;
            cdb_valid  <= '0;
            cdb_rob_id <= '0;
            cdb_pd     <= '0;
            cdb_rd_we  <= '0;
            cdb_value  <= '0;
        end else begin
            rr <= rr_nxt;
            for (int i = 0; i < N_FU; i++) begin
                if (push[i] && !pop[i]) cnt[i] <= cnt[i] + CW'(1);
                else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - CW'(1);
                if (push[i]) tl[i] <= tl[i] + AW'(1);
                if (pop[i])  hd[i] <= hd[i] + AW'(1);
            end
            for (int p = 0; p < CDB_PORTS; p++) begin
                cdb_valid[p]  <= pv[p];
                cdb_rob_id[p] <= pv[p] ? pent[p].rob   : '0;
                cdb_pd[p]     <= pv[p] ? pent[p].pd    : '0;
                cdb_rd_we[p]  <= pv[p] ? pent[p].we    : 1'b0;
                cdb_value[p]  <= pv[p] ? pent[p].value : '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: queue-based reference model plus directed cases.
// Honours CDB_BYPASS_EN when the design is built with it.
module tb_cdb_writeback_arbiter;

    localparam int N = 4;
    localparam int P = 2;
    localparam int D = 4;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [N-1:0]        fu_valid;
    logic [N-1:0]        fu_ready;
    logic [N-1:0][2:0]   fu_rob_id;
    logic [N-1:0][5:0]   fu_pd;
    logic [N-1:0]        fu_rd_we;
    logic [N-1:0][31:0]  fu_value;
    logic [P-1:0]        cdb_valid;
    logic [P-1:0][2:0]   cdb_rob_id;
    logic [P-1:0][5:0]   cdb_pd;
    logic [P-1:0]        cdb_rd_we;
    logic [P-1:0][31:0]  cdb_value;

    cdb_writeback_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob_id(fu_rob_id), .fu_pd(fu_pd),
        .fu_rd_we(fu_rd_we), .fu_value(fu_value),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_pd(cdb_pd), .cdb_rd_we(cdb_rd_we),
        .cdb_value(cdb_value)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  rob;
        logic [5:0]  pd;
        logic        we;
        logic [31:0] v;
    } ent_t;

    ent_t       q [N][$];
    ent_t       ex [P];
    logic [P-1:0] ev;
    int         rr;

    function automatic logic [N-1:0] mready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = rst && (q[i].size() < D);
        return r;
    endfunction

    // Reference: queues per lane, round-robin scan, pop then push
    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            ev = '0;
            rr = 0;
        end else begin
            bit acc [N];
            int n;
            int last;
            for (int i = 0; i < N; i++) acc[i] = fu_valid[i] && (q[i].size() < D);
            ev = '0;
            n = 0;
            last = -1;
            for (int k = 0; k < N; k++) begin
                int l;
                bit c;
                l = (rr + k) % N;
                c = q[l].size() != 0;
`ifdef CDB_BYPASS_EN
                c = c || acc[l];
`endif
                if (c && n < P) begin
                    if (q[l].size() != 0) ex[n] = q[l].pop_front();
                    else begin
                        ex[n] = '{fu_rob_id[l], fu_pd[l], fu_rd_we[l], fu_value[l]};
                        acc[l] = 0;
                    end
                    ev[n] = 1'b1;
                    n++;
                    last = l;
                end
            end
            if (last >= 0) rr = (last + 1) % N;
            for (int i = 0; i < N; i++)
                if (acc[i]) q[i].push_back('{fu_rob_id[i], fu_pd[i], fu_rd_we[i], fu_value[i]});
        end
    end

    bit      bp_mon = 0;
    logic [5:0] l2 [$];

    always @(posedge clk) begin
        #1;
        chk("fu_ready", 64'(fu_ready), 64'(mready()));
        chk("cdb_valid", 64'(cdb_valid), 64'(ev));
        for (int k = 0; k < P; k++) begin
            if (ev[k] && cdb_valid[k])
                chk($sformatf("port%0d_fields", k),
                    {22'd0, cdb_rob_id[k], cdb_pd[k], cdb_rd_we[k], cdb_value[k]},
                    {22'd0, ex[k].rob, ex[k].pd, ex[k].we, ex[k].v});
            if (bp_mon && cdb_valid[k] && cdb_pd[k][5:4] == 2'd2) l2.push_back(cdb_pd[k]);
        end
    end

    task automatic idle();
        fu_valid  = '0;
        fu_rob_id = '0;
        fu_pd     = '0;
        fu_rd_we  = '0;
        fu_value  = '0;
    endtask

    task automatic drive(int i, logic [2:0] rob, logic [5:0] pd, logic [31:0] v);
        fu_valid[i]  = 1'b1;
        fu_rob_id[i] = rob;
        fu_pd[i]     = pd;
        fu_rd_we[i]  = 1'b1;
        fu_value[i]  = v;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int idx;
        bit sawlow;
        bit r2;
        rst = 1'b0;
        flush = 1'b0;
        idle();
        for (int i = 0; i < N; i++) drive(i, 3'(i), 6'(i), 32'h1000 + i);
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 64'(cdb_valid), 64'd0);
            chk("rst_ready", 64'(fu_ready), 64'd0);
        end
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("ready_after_rst", 64'(fu_ready), 64'hF);
        chk("empty_after_rst", 64'(cdb_valid), 64'd0);

        drive(0, 3'd3, 6'd17, 32'hDEADBEEF);
        @(negedge clk);
        idle();
        if (LAT == 2) @(negedge clk);
        chk("single_valid", 64'(cdb_valid), 64'b01);
        chk("single_value", 64'(cdb_value[0]), 64'hDEADBEEF);
        chk("single_rob", 64'(cdb_rob_id[0]), 64'd3);
        chk("single_pd", 64'(cdb_pd[0]), 64'd17);
        repeat (3) @(negedge clk);

        do_flush();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) drive(i, 3'(i + 4 * (1 - b)), 6'(i), 32'(100 + i));
            @(negedge clk);
            idle();
            repeat (LAT - 1) @(negedge clk);
            chk("burst_first_valid", 64'(cdb_valid), 64'b11);
            chk("burst_first_rob", 64'(cdb_rob_id), b == 0 ? 64'o54 : 64'o10);
            @(negedge clk);
            chk("burst_second_rob", 64'(cdb_rob_id), b == 0 ? 64'o76 : 64'o32);
            repeat (3) @(negedge clk);
        end

        do_flush();
        bp_mon = 1;
        idx = 0;
        sawlow = 0;
        for (int c = 0; c < 60 && idx < 6; c++) begin
            for (int i = 0; i < N; i++)
                if (i != 2) drive(i, 3'(c), 6'({2'(i), 4'(c)}), 32'(c));
            drive(2, 3'(idx), 6'({2'd2, 4'(idx)}), 32'hA0 + 32'(idx));
            r2 = fu_ready[2];
            @(negedge clk);
            if (r2) idx++;
            if (!fu_ready[2]) sawlow = 1;
        end
        chk("bp_all_pushed", 64'(idx), 64'd6);
        fu_valid[2] = 1'b0;
        repeat (4) @(negedge clk);
        idle();
        repeat (20) @(negedge clk);
        bp_mon = 0;
`ifndef CDB_BYPASS_EN
        chk("bp_ready_dropped", 64'(sawlow), 64'd1);
`endif
        chk("bp_count", 64'(l2.size()), 64'd6);
        for (int i = 0; i < 6 && i < l2.size(); i++)
            chk("bp_order", 64'(l2[i]), 64'({2'd2, 4'(i)}));

        do_flush();
        for (int i = 0; i < 3; i++) drive(i, 3'(i), 6'(i), 32'h55 + i);
        @(negedge clk);
        flush = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 3'(i), 6'(i), 32'h77);
        @(negedge clk);
        flush = 1'b0;
        idle();
        repeat (4) begin
            chk("flush_quiet", 64'(cdb_valid), 64'd0);
            chk("flush_ready", 64'(fu_ready), 64'hF);
            @(negedge clk);
        end

        for (int i = 0; i < N; i++) drive(i, 3'(i), 6'(i), 32'h99);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(cdb_valid), 64'd0);
        chk("async_rst_ready", 64'(fu_ready), 64'd0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                fu_valid[i]  = $urandom_range(0, 99) < 60;
                fu_rob_id[i] = 3'($urandom);
                fu_pd[i]     = 6'($urandom);
                fu_rd_we[i]  = 1'($urandom);
                fu_value[i]  = $urandom;
            end
            flush = $urandom_range(0, 49) == 0;
            @(negedge clk);
        end
        flush = 1'b0;
        idle();
        repeat (30) @(negedge clk);
        for (int i = 0; i < N; i++) chk("soak_drained", 64'(q[i].size()), 64'd0);
        chk("soak_final_valid", 64'(cdb_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
